// File: rtl/fetch_ctrl_pkg.sv
// Shared sizing for the instruction-fetch sequencer and its prefetch buffer.
// Widths fall back to the 16-bit CPU defaults when defines.v is not in the build.
`ifndef INST_ADDR_LENGTH
`define INST_ADDR_LENGTH 8
`endif
`ifndef INST_BUS_LENGTH
`define INST_BUS_LENGTH 16
`endif
`ifndef ROM_DEPTH
`define ROM_DEPTH 38
`endif

package fetch_ctrl_pkg;

    localparam int ADDR_W    = `INST_ADDR_LENGTH;
    localparam int INST_W    = `INST_BUS_LENGTH;
    localparam int ROM_DEPTH = `ROM_DEPTH;
    localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/fetch_buf.sv
// Prefetch FIFO of packed {pc, inst} entries with push, pop, flush and count.
// Storage is not reset; the consumer masks the head while the count is zero.
module fetch_buf
    import fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH,
    parameter int W     = ADDR_W + INST_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [W-1:0]     wdata_i,
    output logic [W-1:0]     rdata_o,
    output logic [CNT_W-1:0] count_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop, full;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i & (count_q != '0);
    // A full buffer may still accept a write when its head leaves this cycle.
    assign do_push = push_i & (!full | do_pop) & !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
            if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives IMEM and feeds decode through a
// small prefetch buffer; execute redirects reload the PC and flush.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W    = fetch_ctrl_pkg::ADDR_W,
    parameter int INST_W    = fetch_ctrl_pkg::INST_W,
    parameter int ROM_DEPTH = fetch_ctrl_pkg::ROM_DEPTH,
    parameter int BUF_DEPTH = fetch_ctrl_pkg::BUF_DEPTH,
    localparam int CNT_W = $clog2(BUF_DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [INST_W-1:0] imem_inst_i,
    output logic              id_valid_o,
    input  logic              id_ready_i,
    output logic [INST_W-1:0] id_inst_o,
    output logic [ADDR_W-1:0] id_pc_o,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              end_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W+INST_W-1:0] head;
    logic in_rom, full, pop, fetch;

    assign in_rom = (pc_q < ADDR_W'(ROM_DEPTH));
    assign full   = (count == CNT_W'(BUF_DEPTH));
    assign pop    = id_valid_o & id_ready_i;
    assign fetch  = !redirect_i & in_rom & (!full | pop);

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i;
        end else if (fetch) begin
            // Only reached while in_rom, so the increment cannot wrap.
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_buf #(
        .DEPTH (BUF_DEPTH),
        .W     (ADDR_W + INST_W)
    ) u_buf (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (fetch),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .wdata_i ({pc_q, imem_inst_i}),
        .rdata_o (head),
        .count_o (count)
    );

    assign imem_addr_o = pc_q;
    assign id_valid_o  = (count != '0);
    assign id_pc_o     = id_valid_o ? head[ADDR_W+INST_W-1:INST_W] : '0;
    assign id_inst_o   = id_valid_o ? head[INST_W-1:0] : '0;
    assign end_o       = !in_rom & (count == '0);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with an IMEM model and a delivery
// scoreboard of expected PCs checked whenever decode accepts the head.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [INST_W-1:0] imem_inst_i;
    logic              id_valid_o;
    logic              id_ready_i;
    logic [INST_W-1:0] id_inst_o;
    logic [ADDR_W-1:0] id_pc_o;
    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic              end_o;

    int n_chk = 0;
    int n_fail = 0;
    int last_pc = -1;
    int sb[$];

    always #5 clk_i = ~clk_i;

    function automatic logic [INST_W-1:0] rom(input int a);
        case (a)
            0:  return 16'h8800;
            1:  return 16'h8901;
            24: return 16'hBA62;
            33: return 16'hE002;
            default: return (a < ROM_DEPTH) ? (16'h4000 | 16'(a)) : 16'h0000;
        endcase
    endfunction

    assign imem_inst_i = rom(int'(imem_addr_o));

    fetch_ctrl dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .imem_addr_o   (imem_addr_o),
        .imem_inst_i   (imem_inst_i),
        .id_valid_o    (id_valid_o),
        .id_ready_i    (id_ready_i),
        .id_inst_o     (id_inst_o),
        .id_pc_o       (id_pc_o),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .end_o         (end_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_addr"},  32'(imem_addr_o), 32'd0);
        chk({tag, "_valid"}, 32'(id_valid_o),  32'd0);
        chk({tag, "_inst"},  32'(id_inst_o),   32'd0);
        chk({tag, "_pc"},    32'(id_pc_o),     32'd0);
        chk({tag, "_end"},   32'(end_o),       32'd0);
    endtask

    // Score the head if it is accepted at the coming edge, then advance.
    task automatic tick();
        int e;
        #1;
        if (id_valid_o && id_ready_i) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_pc", 32'(id_pc_o), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("sb_pc", 32'(id_pc_o), 32'(e));
                chk("sb_inst", 32'(id_inst_o), 32'(rom(e)));
                last_pc = int'(id_pc_o);
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic restart(input logic rdy);
        rst_n_i = 1'b0;
        #1;
        sb.delete();
        @(posedge clk_i);
        #1;
        id_ready_i = rdy;
        redirect_i = 1'b0;
        rst_n_i = 1'b1;
    endtask

    initial begin
        int n;
        rst_n_i = 1'b0;
        id_ready_i = 1'b1;
        redirect_i = 1'b0;
        redirect_pc_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk_reset_outs("reset");

        // Streaming from reset
        rst_n_i = 1'b1;
        for (int i = 0; i < 6; i++) sb.push_back(i);
        tick();
        chk("t1_valid", 32'(id_valid_o), 32'd1);
        chk("t1_pc0", 32'(id_pc_o), 32'd0);
        chk("t1_inst0", 32'(id_inst_o), 32'h8800);
        tick();
        chk("t1_pc1", 32'(id_pc_o), 32'd1);
        chk("t1_inst1", 32'(id_inst_o), 32'h8901);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_stream_valid", 32'(id_valid_o), 32'd1);
        end
        chk("t1_sb_left", 32'(sb.size()), 32'd1);

        // Backpressure
        restart(1'b0);
        for (int i = 0; i < 3; i++) sb.push_back(i);
        repeat (5) tick();
        chk("t2_addr", 32'(imem_addr_o), 32'd2);
        chk("t2_valid", 32'(id_valid_o), 32'd1);
        chk("t2_head_pc", 32'(id_pc_o), 32'd0);
        chk("t2_head_inst", 32'(id_inst_o), 32'h8800);
        id_ready_i = 1'b1;
        repeat (3) begin
            chk("t2_drain_valid", 32'(id_valid_o), 32'd1);
            tick();
        end
        chk("t2_sb_empty", 32'(sb.size()), 32'd0);

        // Redirect with a full buffer and a same-cycle pop
        restart(1'b0);
        repeat (3) tick();
        id_ready_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 8'd24;
        sb.push_back(0);
        sb.push_back(24);
        sb.push_back(25);
        tick();
        redirect_i = 1'b0;
        chk("t3_flush_valid", 32'(id_valid_o), 32'd0);
        tick();
        chk("t3_tgt_valid", 32'(id_valid_o), 32'd1);
        chk("t3_tgt_pc", 32'(id_pc_o), 32'd24);
        chk("t3_tgt_inst", 32'(id_inst_o), 32'hBA62);
        repeat (2) tick();
        chk("t3_sb_empty", 32'(sb.size()), 32'd0);

        // Free run to the end of the program
        restart(1'b1);
        for (int i = 0; i < ROM_DEPTH; i++) sb.push_back(i);
        n = 0;
        while (!end_o && n < 100) begin
            tick();
            n++;
        end
        chk("t4_end", 32'(end_o), 32'd1);
        chk("t4_sb_empty", 32'(sb.size()), 32'd0);
        chk("t4_last_pc", 32'(last_pc), 32'd37);
        chk("t4_pc_sat", 32'(imem_addr_o), 32'd38);
        repeat (2) tick();
        chk("t4_pc_hold", 32'(imem_addr_o), 32'd38);
        chk("t4_end_hold", 32'(end_o), 32'd1);
        redirect_i = 1'b1;
        redirect_pc_i = 8'd33;
        tick();
        redirect_i = 1'b0;
        chk("t4_end_clr", 32'(end_o), 32'd0);
        sb.push_back(33);
        tick();
        chk("t4_res_pc", 32'(id_pc_o), 32'd33);
        chk("t4_res_inst", 32'(id_inst_o), 32'hE002);
        tick();
        id_ready_i = 1'b0;
        chk("t4_sb_empty2", 32'(sb.size()), 32'd0);

        // Back-to-back redirects and an out-of-program target
        restart(1'b0);
        repeat (3) tick();
        redirect_i = 1'b1;
        redirect_pc_i = 8'd5;
        tick();
        chk("t5_flush1", 32'(id_valid_o), 32'd0);
        redirect_pc_i = 8'd10;
        tick();
        chk("t5_flush2", 32'(id_valid_o), 32'd0);
        redirect_pc_i = 8'd30;
        tick();
        redirect_i = 1'b0;
        id_ready_i = 1'b1;
        chk("t5_flush3", 32'(id_valid_o), 32'd0);
        chk("t5_addr30", 32'(imem_addr_o), 32'd30);
        sb.push_back(30);
        sb.push_back(31);
        tick();
        chk("t5_pc30", 32'(id_pc_o), 32'd30);
        repeat (2) tick();
        id_ready_i = 1'b0;
        chk("t5_sb_empty", 32'(sb.size()), 32'd0);
        redirect_i = 1'b1;
        redirect_pc_i = 8'd40;
        tick();
        redirect_i = 1'b0;
        chk("t5_end40", 32'(end_o), 32'd1);
        chk("t5_addr40", 32'(imem_addr_o), 32'd40);
        chk("t5_valid40", 32'(id_valid_o), 32'd0);
        tick();
        chk("t5_nofetch_valid", 32'(id_valid_o), 32'd0);
        chk("t5_nofetch_addr", 32'(imem_addr_o), 32'd40);

        // Asynchronous reset in the middle of a cycle
        restart(1'b0);
        repeat (3) tick();
        chk("t6_full_valid", 32'(id_valid_o), 32'd1);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk_reset_outs("t6_async");
        sb.delete();
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        id_ready_i = 1'b1;
        sb.push_back(0);
        tick();
        chk("t6_pc0", 32'(id_pc_o), 32'd0);
        chk("t6_inst0", 32'(id_inst_o), 32'h8800);
        tick();
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer that owns the program counter and drives the combinational instruction ROM.
- Each fetched {pc, instruction} pair goes into a small prefetch buffer and is handed to decode over a valid/ready handshake.
- Execute-stage redirects (jeq/jne/jg/jgu/jl/jlu/jmpi/jmp) load a new PC and flush the buffer.
- Sits between IMEM and the decode stage of the 16-bit CPU.

Parameters:
- ADDR_W, `INST_ADDR_LENGTH, PC / ROM address width
- INST_W, `INST_BUS_LENGTH, instruction width (16)
- ROM_DEPTH, 38, number of valid ROM words; addresses >= ROM_DEPTH are outside the program
- BUF_DEPTH, 2, prefetch buffer entries (power of two, >= 2)

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- imem_addr_o  out  ADDR_W  address to IMEM; equals the internal PC register
- imem_inst_i  in  INST_W  IMEM read data; combinational from imem_addr_o, same cycle
- id_valid_o  out  1  buffer head holds a valid instruction
- id_ready_i  in  1  decode accepts the head this cycle
- id_inst_o  out  INST_W  head instruction
- id_pc_o  out  ADDR_W  PC of the head instruction
- redirect_i  in  1  execute requests a PC change (taken branch or jump)
- redirect_pc_i  in  ADDR_W  absolute target PC
- end_o  out  1  PC >= ROM_DEPTH and buffer empty (program drained)

Behaviour:
- Reset (async, rst_n_i=0): PC=0, buffer count=0, rd/wr pointers=0.
  - Outputs: imem_addr_o=0, id_valid_o=0, id_inst_o=0, id_pc_o=0, end_o=0.
  - Buffer data does not need reset; outputs are masked to 0 while empty.
- pop = id_valid_o & id_ready_i.
- fetch = !redirect_i & (PC < ROM_DEPTH) & (count < BUF_DEPTH | pop).
- On fetch: write {PC, imem_inst_i} at the write pointer, then PC <= PC+1.
- Simultaneous fetch and pop keeps count unchanged. A full buffer with a pop still fetches, so there is no bubble.
- Pointers wrap modulo BUF_DEPTH. Count never exceeds BUF_DEPTH and never underflows.
- id_valid_o = (count != 0). id_inst_o and id_pc_o come from registered buffer storage; there is no combinational path from imem_inst_i to the id_* outputs.
- Latency:
  - First instruction after reset release: id_valid_o=1 in the cycle after the first fetch edge.
  - Sustained throughput with id_ready_i=1: one instruction per cycle.
- Backpressure: with id_ready_i=0, the head and its data stay stable until accepted. Fetch stops when full and the PC holds.
- Redirect (highest priority):
  - In a cycle with redirect_i=1, a pop that same cycle still completes; decode is responsible for squashing.
  - At the edge: every entry is flushed (count=0, pointers=0) and PC <= redirect_pc_i. No fetch occurs that cycle.
  - id_valid_o is 0 in the cycle after the redirect edge. The target instruction appears one cycle later.
  - Back-to-back redirects: the last one wins and each one flushes.
- End of program:
  - When PC reaches ROM_DEPTH, fetch stops and the PC saturates; no increment and no wrap to 0.
  - end_o = (PC >= ROM_DEPTH) & (count == 0), registered-state based.
  - A redirect to a target below ROM_DEPTH clears end_o and resumes fetching.
  - A redirect to a target >= ROM_DEPTH sets end_o on the next cycle.
- PC arithmetic: unsigned ADDR_W. PC+1 is computed only while PC < ROM_DEPTH, so it never overflows ADDR_W.
- Reset mid-operation: asynchronous return to the reset state within the same cycle. Buffered instructions are discarded.

Decomposition:
- Shared defines: ADDR_W/INST_W come from the existing `INST_ADDR_LENGTH/`INST_BUS_LENGTH. Add `ROM_DEPTH to defines.v so IMEM and fetch_ctrl agree.
- One sub-module is natural: fetch_buf, a BUF_DEPTH-entry sync FIFO of {pc, inst} with push/pop/flush and count.
- fetch_ctrl holds the PC register, fetch/redirect decision and end_o logic.

Test Plan:
1. Reset release, id_ready_i=1, IMEM model loaded with the current program:
   - cycle 1: id_valid_o=1, id_pc_o=0, id_inst_o=16'h8800.
   - cycle 2: id_pc_o=1, id_inst_o=16'h8901.
   - then one instruction per cycle.
2. Backpressure: id_ready_i=0 from reset for 5 cycles:
   - buffer holds PC 0 and 1; imem_addr_o stuck at 2; id_inst_o stays 16'h8800.
   - releasing id_ready_i delivers PC 0, 1, 2 in consecutive cycles with no loss or duplicate.
3. Redirect: redirect_i=1, redirect_pc_i=24 while the buffer is full and id_ready_i=1:
   - the head transfer in that cycle counts.
   - next cycle id_valid_o=0; following cycle id_pc_o=24, id_inst_o=16'hBA62.
4. End: free-run from reset:
   - last delivered id_pc_o=37; PC saturates at 38.
   - end_o=1 once drained; a redirect to 33 clears end_o and delivers 16'hE002 two cycles later.
5. Simultaneous and edge events:
   - redirect_i held 3 consecutive cycles with targets 5, 10, 30: only target 30 is delivered.
   - redirect_pc_i=40: end_o=1 next cycle, no fetch.
6. Reset asserted mid-stream with the buffer full:
   - outputs drop to reset values immediately, without waiting for a clock.
   - after release, delivery restarts at PC 0 with 16'h8800.
